// File: rtl/sram_phase_pkg.sv
// Shared types and phase-slot helpers for the SRAM phase sequencer and its phase monitor.
package sram_phase_pkg;

  localparam int PHASE_W = 8;

  // Phase 0 is the first fast cycle after the system rising edge.
  localparam logic [PHASE_W-1:0] PH_START = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WPULSE,
    ST_WHOLD,
    ST_RDWAIT,
    ST_DONE
  } seq_state_t;

  function automatic logic [PHASE_W-1:0] ph_capture(input int ratio);
    return PHASE_W'(ratio - 2);
  endfunction

  function automatic logic [PHASE_W-1:0] ph_last(input int ratio);
    return PHASE_W'(ratio - 1);
  endfunction

endpackage

// File: rtl/sram_phase_monitor.sv
// Checks that the fast-clock phase index counts 0..R-1 without gaps and declares lock
// after LOCK_PERIODS consecutive clean wraps.
module sram_phase_monitor
  import sram_phase_pkg::*;
#(
  parameter int RATIO        = 10,
  parameter int LOCK_PERIODS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] phase,
  output logic               phase_locked,
  output logic               phase_error
);

  localparam int LCNT_W = $clog2(LOCK_PERIODS + 1);

  logic [PHASE_W-1:0] r_prev;
  logic               r_primed;
  logic [LCNT_W-1:0]  r_good;
  logic               r_locked;
  logic               r_error;

  logic               w_last;
  logic [PHASE_W-1:0] w_expect;
  logic               w_bad;

  assign w_last   = (r_prev == ph_last(RATIO));
  assign w_expect = w_last ? PH_START : r_prev + PHASE_W'(1);
  assign w_bad    = (phase >= PHASE_W'(RATIO)) || (phase != w_expect);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      // Always track the latest sample so a single glitch resynchronises next cycle.
      r_prev   <= phase;
      r_primed <= 1'b1;
      r_error  <= 1'b0;
      if (r_primed) begin
        if (w_bad) begin
          r_error  <= 1'b1;
          r_locked <= 1'b0;
          r_good   <= '0;
        end else if (w_last && (r_good != LCNT_W'(LOCK_PERIODS))) begin
          r_good <= r_good + LCNT_W'(1);
          if (r_good == LCNT_W'(LOCK_PERIODS - 1)) r_locked <= 1'b1;
        end
      end
    end
  end

  assign phase_locked = r_locked;
  assign phase_error  = r_error;

endmodule

// File: rtl/sram_phase_sequencer.sv
// Schedules one async-SRAM read or write per system period using the fast-clock phase index.
// Define SRAM_PHASE_CHECK_EN to gate and abort accesses on phase-sequence faults.
module sram_phase_sequencer
  import sram_phase_pkg::*;
#(
  parameter int MEMORY_TO_SYSTEM_CLOCK_RATIO = 10,
  parameter int ADDR_WIDTH                   = 18,
  parameter int DATA_WIDTH                   = 16,
  parameter int WRITE_PULSE_CYCLES           = 2,
  parameter int LOCK_PERIODS                 = 4
) (
  input  logic                  modified_clock_sram,
  input  logic                  reset,
  input  logic [PHASE_W-1:0]    modified_clock_period,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dq_out,
  input  logic [DATA_WIDTH-1:0] sram_dq_in,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  phase_locked,
  output logic                  phase_error
);

  localparam int                 R      = MEMORY_TO_SYSTEM_CLOCK_RATIO;
  localparam logic [PHASE_W-1:0] PH_CAP = ph_capture(R);
  localparam logic [PHASE_W-1:0] PH_END = ph_last(R);
  localparam int                 CNT_W  = $clog2(WRITE_PULSE_CYCLES + 1);

  seq_state_t            r_state;
  logic [CNT_W-1:0]      r_pulse_cnt;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_dq_out;
  logic                  r_dq_oe;
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;

  logic w_locked;
  logic w_accept;

`ifdef SRAM_PHASE_CHECK_EN
  sram_phase_monitor #(
    .RATIO        (R),
    .LOCK_PERIODS (LOCK_PERIODS)
  ) u_mon (
    .clk          (modified_clock_sram),
    .reset        (reset),
    .phase        (modified_clock_period),
    .phase_locked (phase_locked),
    .phase_error  (phase_error)
  );
  assign w_locked = phase_locked;
`else
  assign phase_locked = 1'b1;
  assign phase_error  = 1'b0;
  assign w_locked     = 1'b1;
`endif

  assign w_accept = (r_state == ST_IDLE) && (modified_clock_period == PH_START) &&
                    req_valid && r_req_ready && w_locked;

  always_ff @(posedge modified_clock_sram) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pulse_cnt <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_addr      <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
    end else begin
      if (modified_clock_period == PH_END)
        r_req_ready <= ((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_locked;
      // Response window is re-evaluated only at the capture slot, giving exactly R cycles.
      if (modified_clock_period == PH_CAP) r_rsp_valid <= 1'b0;

      if ((r_state != ST_IDLE) && !w_locked) begin
        r_we_n  <= 1'b1;
        r_ce_n  <= 1'b1;
        r_oe_n  <= 1'b1;
        r_dq_oe <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (w_accept) begin
            r_addr <= req_addr;
            r_ce_n <= 1'b0;
            if (req_we) begin
              r_dq_oe  <= 1'b1;
              r_dq_out <= req_wdata;
              r_state  <= ST_SETUP;
            end else begin
              r_oe_n  <= 1'b0;
              r_state <= ST_RDWAIT;
            end
          end
          ST_SETUP: begin
            r_we_n      <= 1'b0;
            r_pulse_cnt <= '0;
            r_state     <= ST_WPULSE;
          end
          ST_WPULSE: begin
            if (r_pulse_cnt == CNT_W'(WRITE_PULSE_CYCLES - 1)) begin
              r_we_n  <= 1'b1;
              r_state <= ST_WHOLD;
            end else begin
              r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
            end
          end
          ST_WHOLD: begin
            r_ce_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_state <= ST_DONE;
          end
          ST_RDWAIT: if (modified_clock_period == PH_CAP) begin
            r_rsp_rdata <= sram_dq_in;
            r_rsp_valid <= 1'b1;
            r_oe_n      <= 1'b1;
            r_ce_n      <= 1'b1;
            r_state     <= ST_DONE;
          end
          ST_DONE: if (modified_clock_period == PH_END) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;

endmodule
